// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multi-cycle MIPS-subset control sequencer with memory ready stall.
//            Optional memory-timeout trap enabled by defining MC_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mc_ctrl_fsm #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic [5:0]       instr_funct_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             pc_write_cond_o,
    output logic [1:0]       pc_source_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             ir_write_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       branch_type_o,
    output logic             illegal_o,
    output logic             trap_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [3:0]       state_o
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNEZ  = 6'd5;
    localparam logic [5:0] OP_BLT   = 6'd6;
    localparam logic [5:0] OP_BLE   = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LI    = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I  = 4'd3,
        S_WB_ALU   = 4'd4,  S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6,  S_MEM_WR  = 4'd7,
        S_WB_MEM   = 4'd8,  S_BRANCH  = 4'd9,  S_JUMP   = 4'd10, S_JR      = 4'd11,
        S_JAL      = 4'd12, S_LI_WB   = 4'd13, S_ILLEGAL = 4'd14, S_TRAP   = 4'd15
    } state_t;

    state_t           state_q, state_d;
    logic             regdst_rd_q, regdst_rd_d;
    logic [CNT_W-1:0] count_q;
    logic             w_retire;
    logic             w_timeout;

`ifdef MC_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            w_waiting;

    // Only the three handshake states can stall; leaving them clears the run.
    assign w_waiting  = !mem_ready_i &&
                        ((state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR));
    assign wait_cnt_d = w_waiting ? (wait_cnt_q + 1'b1) : '0;
    assign w_timeout  = w_waiting && (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    // Timeout disabled: constant-false, waits are unbounded.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_FETCH;
            regdst_rd_q <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            regdst_rd_q <= regdst_rd_d;
            if (w_retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        regdst_rd_d     = regdst_rd_q;
        w_retire        = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = 2'd0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 2'd0;
        mem_to_reg_o    = 2'd0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'd0;
        alu_op_o        = 4'd0;
        branch_type_o   = 2'd0;
        illegal_o       = 1'b0;
        trap_o          = 1'b0;
        // Strobes are forced quiet while reset is held, whatever the state.
        if (!rst_i) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'd1;
                    alu_op_o    = 4'd10;
                    if (mem_ready_i) begin
                        ir_write_o = 1'b1;
                        pc_write_o = 1'b1;
                        state_d    = S_DECODE;
                    end else if (w_timeout) begin
                        state_d = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b_o = 2'd3;
                    alu_op_o    = 4'd11;
                    case (instr_op_i)
                        OP_RTYPE:                        state_d = (instr_funct_i == FN_JR) ? S_JR : S_EXEC_R;
                        OP_J:                            state_d = S_JUMP;
                        OP_JAL:                          state_d = S_JAL;
                        OP_BEQ, OP_BNEZ, OP_BLT, OP_BLE: state_d = S_BRANCH;
                        OP_ADDI, OP_ORI:                 state_d = S_EXEC_I;
                        OP_LI:                           state_d = S_LI_WB;
                        OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                        default:                         state_d = S_ILLEGAL;
                    endcase
                end
                S_EXEC_R: begin
                    alu_src_a_o = 1'b1;
                    regdst_rd_d = 1'b1;
                    state_d     = S_WB_ALU;
                end
                S_EXEC_I: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    alu_op_o    = (instr_op_i == OP_ORI) ? 4'd7 : 4'd6;
                    regdst_rd_d = 1'b0;
                    state_d     = S_WB_ALU;
                end
                S_WB_ALU: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = regdst_rd_q ? 2'd1 : 2'd0;
                    w_retire    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_MEM_ADDR: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = 2'd2;
                    alu_op_o    = (instr_op_i == OP_SW) ? 4'd9 : 4'd8;
                    state_d     = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    iord_o     = 1'b1;
                    mem_read_o = 1'b1;
                    if (mem_ready_i) begin
                        state_d = S_WB_MEM;
                    end else if (w_timeout) begin
                        state_d = S_TRAP;
                    end
                end
                S_MEM_WR: begin
                    iord_o      = 1'b1;
                    mem_write_o = 1'b1;
                    if (mem_ready_i) begin
                        w_retire = 1'b1;
                        state_d  = S_FETCH;
                    end else if (w_timeout) begin
                        state_d = S_TRAP;
                    end
                end
                S_WB_MEM: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'd1;
                    w_retire     = 1'b1;
                    state_d      = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = 2'd1;
                    // Branch opcodes 4..7 differ only in their two low bits.
                    case (instr_op_i[1:0])
                        2'd0:    begin alu_op_o = 4'd2; branch_type_o = 2'd0; end
                        2'd1:    begin alu_op_o = 4'd3; branch_type_o = 2'd3; end
                        2'd2:    begin alu_op_o = 4'd4; branch_type_o = 2'd2; end
                        default: begin alu_op_o = 4'd5; branch_type_o = 2'd1; end
                    endcase
                    w_retire = 1'b1;
                    state_d  = S_FETCH;
                end
                S_JUMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 2'd2;
                    w_retire    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_JR: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = 2'd3;
                    w_retire    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_JAL: begin
                    pc_write_o   = 1'b1;
                    pc_source_o  = 2'd2;
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'd2;
                    mem_to_reg_o = 2'd3;
                    w_retire     = 1'b1;
                    state_d      = S_FETCH;
                end
                S_LI_WB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 2'd2;
                    w_retire     = 1'b1;
                    state_d      = S_FETCH;
                end
                S_ILLEGAL: begin
                    illegal_o = 1'b1;
                    state_d   = S_FETCH;
                end
                S_TRAP: begin
`ifdef MC_CTRL_TIMEOUT_EN
                    trap_o = 1'b1;
`endif
                    state_d = S_TRAP;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    assign instr_count_o = count_q;
    assign state_o       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Table-driven directed bench for mc_ctrl_fsm plus latency/stall runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] branch_type;
        logic       illegal;
        logic       trap;
    } ctl_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       rdy;
        logic [3:0] st;
        ctl_t       exp;
        int         cnt;
    } vec_t;

    localparam ctl_t E_Z    = '{default: '0};
    localparam ctl_t E_FW   = '{mem_read: 1'b1, alu_src_b: 2'd1, alu_op: 4'd10, default: '0};
    localparam ctl_t E_FR   = '{pc_write: 1'b1, mem_read: 1'b1, ir_write: 1'b1, alu_src_b: 2'd1, alu_op: 4'd10, default: '0};
    localparam ctl_t E_DEC  = '{alu_src_b: 2'd3, alu_op: 4'd11, default: '0};
    localparam ctl_t E_ADDI = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_op: 4'd6, default: '0};
    localparam ctl_t E_ORI  = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_op: 4'd7, default: '0};
    localparam ctl_t E_EXR  = '{alu_src_a: 1'b1, default: '0};
    localparam ctl_t E_WBRT = '{reg_write: 1'b1, default: '0};
    localparam ctl_t E_WBRD = '{reg_write: 1'b1, reg_dst: 2'd1, default: '0};
    localparam ctl_t E_LWA  = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_op: 4'd8, default: '0};
    localparam ctl_t E_SWA  = '{alu_src_a: 1'b1, alu_src_b: 2'd2, alu_op: 4'd9, default: '0};
    localparam ctl_t E_MRD  = '{iord: 1'b1, mem_read: 1'b1, default: '0};
    localparam ctl_t E_MWR  = '{iord: 1'b1, mem_write: 1'b1, default: '0};
    localparam ctl_t E_WBM  = '{reg_write: 1'b1, mem_to_reg: 2'd1, default: '0};
    localparam ctl_t E_BEQ  = '{pc_write_cond: 1'b1, pc_source: 2'd1, alu_src_a: 1'b1, alu_op: 4'd2, branch_type: 2'd0, default: '0};
    localparam ctl_t E_BNE  = '{pc_write_cond: 1'b1, pc_source: 2'd1, alu_src_a: 1'b1, alu_op: 4'd3, branch_type: 2'd3, default: '0};
    localparam ctl_t E_BLT  = '{pc_write_cond: 1'b1, pc_source: 2'd1, alu_src_a: 1'b1, alu_op: 4'd4, branch_type: 2'd2, default: '0};
    localparam ctl_t E_BLE  = '{pc_write_cond: 1'b1, pc_source: 2'd1, alu_src_a: 1'b1, alu_op: 4'd5, branch_type: 2'd1, default: '0};
    localparam ctl_t E_J    = '{pc_write: 1'b1, pc_source: 2'd2, default: '0};
    localparam ctl_t E_JR   = '{pc_write: 1'b1, pc_source: 2'd3, default: '0};
    localparam ctl_t E_JAL  = '{pc_write: 1'b1, pc_source: 2'd2, reg_write: 1'b1, reg_dst: 2'd2, mem_to_reg: 2'd3, default: '0};
    localparam ctl_t E_LI   = '{reg_write: 1'b1, mem_to_reg: 2'd2, default: '0};
    localparam ctl_t E_ILL  = '{illegal: 1'b1, default: '0};

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [5:0]  instr_op_i = '0;
    logic [5:0]  instr_funct_i = '0;
    logic        mem_ready_i = 1'b1;
    logic        pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
    logic        ir_write_o, reg_write_o, alu_src_a_o, illegal_o, trap_o;
    logic [1:0]  pc_source_o, reg_dst_o, mem_to_reg_o, alu_src_b_o, branch_type_o;
    logic [3:0]  alu_op_o, state_o;
    logic [31:0] instr_count_o;
    ctl_t        act;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    logic [5:0] lat_op[5]  = '{6'd35, 6'd43, 6'd0, 6'd4, 6'd3};
    logic [5:0] lat_fn[5]  = '{6'd0, 6'd0, 6'd32, 6'd0, 6'd0};
    int         lat_exp[5] = '{5, 4, 4, 3, 3};

    mc_ctrl_fsm #(.TIMEOUT_CYCLES(16), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .instr_funct_i(instr_funct_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o),
        .pc_source_o(pc_source_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .reg_write_o(reg_write_o),
        .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .branch_type_o(branch_type_o),
        .illegal_o(illegal_o), .trap_o(trap_o), .instr_count_o(instr_count_o), .state_o(state_o)
    );

    assign act = {pc_write_o, pc_write_cond_o, pc_source_o, iord_o, mem_read_o, mem_write_o,
                  ir_write_o, reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
                  alu_op_o, branch_type_o, illegal_o, trap_o};

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, want);
        end
    endtask

    task automatic add(input string nm, input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic rdy, input logic [3:0] st, input ctl_t e, input int cnt);
        vec_t v;
        v.name = nm; v.rst = rst; v.op = op; v.fn = fn; v.rdy = rdy;
        v.st = st; v.exp = e; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        int cyc;
        int bad;
        logic done;

        // name, rst, op, funct, ready, state, outputs, count
        add("rst",      1, 8,  0,  1, 0,  E_Z,    0);
        add("addi_f",   0, 8,  0,  1, 0,  E_FR,   0);
        add("addi_d",   0, 8,  0,  1, 1,  E_DEC,  0);
        add("addi_x",   0, 8,  0,  1, 3,  E_ADDI, 0);
        add("addi_wb",  0, 8,  0,  1, 4,  E_WBRT, 0);
        add("ori_f",    0, 13, 0,  1, 0,  E_FR,   1);
        add("ori_d",    0, 13, 0,  1, 1,  E_DEC,  1);
        add("ori_x",    0, 13, 0,  1, 3,  E_ORI,  1);
        add("ori_wb",   0, 13, 0,  1, 4,  E_WBRT, 1);
        add("add_f",    0, 0,  32, 1, 0,  E_FR,   2);
        add("add_d",    0, 0,  32, 1, 1,  E_DEC,  2);
        add("add_x",    0, 0,  32, 1, 2,  E_EXR,  2);
        add("add_wb",   0, 0,  32, 1, 4,  E_WBRD, 2);
        add("lw_f",     0, 35, 0,  1, 0,  E_FR,   3);
        add("lw_d",     0, 35, 0,  1, 1,  E_DEC,  3);
        add("lw_a",     0, 35, 0,  1, 5,  E_LWA,  3);
        add("lw_w0",    0, 35, 0,  0, 6,  E_MRD,  3);
        add("lw_w1",    0, 35, 0,  0, 6,  E_MRD,  3);
        add("lw_w2",    0, 35, 0,  0, 6,  E_MRD,  3);
        add("lw_rd",    0, 35, 0,  1, 6,  E_MRD,  3);
        add("lw_wb",    0, 35, 0,  1, 8,  E_WBM,  3);
        add("sw_fw",    0, 43, 0,  0, 0,  E_FW,   4);
        add("sw_f",     0, 43, 0,  1, 0,  E_FR,   4);
        add("sw_d",     0, 43, 0,  0, 1,  E_DEC,  4);
        add("sw_a",     0, 43, 0,  0, 5,  E_SWA,  4);
        add("sw_w",     0, 43, 0,  0, 7,  E_MWR,  4);
        add("sw_wr",    0, 43, 0,  1, 7,  E_MWR,  4);
        add("blt_f",    0, 6,  0,  1, 0,  E_FR,   5);
        add("blt_d",    0, 6,  0,  0, 1,  E_DEC,  5);
        add("blt_b",    0, 6,  0,  0, 9,  E_BLT,  5);
        add("jr_f",     0, 0,  8,  1, 0,  E_FR,   6);
        add("jr_d",     0, 0,  8,  1, 1,  E_DEC,  6);
        add("jr_x",     0, 0,  8,  1, 11, E_JR,   6);
        add("jal_f",    0, 3,  0,  1, 0,  E_FR,   7);
        add("jal_d",    0, 3,  0,  1, 1,  E_DEC,  7);
        add("jal_x",    0, 3,  0,  1, 12, E_JAL,  7);
        add("j_f",      0, 2,  0,  1, 0,  E_FR,   8);
        add("j_d",      0, 2,  0,  1, 1,  E_DEC,  8);
        add("j_x",      0, 2,  0,  1, 10, E_J,    8);
        add("li_f",     0, 15, 0,  1, 0,  E_FR,   9);
        add("li_d",     0, 15, 0,  1, 1,  E_DEC,  9);
        add("li_x",     0, 15, 0,  1, 13, E_LI,   9);
        add("beq_f",    0, 4,  0,  1, 0,  E_FR,   10);
        add("beq_d",    0, 4,  0,  1, 1,  E_DEC,  10);
        add("beq_b",    0, 4,  0,  1, 9,  E_BEQ,  10);
        add("bnez_f",   0, 5,  0,  1, 0,  E_FR,   11);
        add("bnez_d",   0, 5,  0,  1, 1,  E_DEC,  11);
        add("bnez_b",   0, 5,  0,  1, 9,  E_BNE,  11);
        add("ble_f",    0, 7,  0,  1, 0,  E_FR,   12);
        add("ble_d",    0, 7,  0,  1, 1,  E_DEC,  12);
        add("ble_b",    0, 7,  0,  1, 9,  E_BLE,  12);
        add("ill_f",    0, 63, 0,  1, 0,  E_FR,   13);
        add("ill_d",    0, 63, 0,  1, 1,  E_DEC,  13);
        add("ill_x",    0, 63, 0,  1, 14, E_ILL,  13);
        add("ill_next", 0, 43, 0,  0, 0,  E_FW,   13);
        add("rsw_f",    0, 43, 0,  1, 0,  E_FR,   13);
        add("rsw_d",    0, 43, 0,  1, 1,  E_DEC,  13);
        add("rsw_a",    0, 43, 0,  1, 5,  E_SWA,  13);
        add("rsw_w",    0, 43, 0,  0, 7,  E_MWR,  13);
        add("rsw_rst",  1, 43, 0,  0, 7,  E_Z,    13);
        add("rsw_post", 0, 9,  0,  1, 0,  E_FR,   0);
        add("ill9_d",   0, 9,  0,  1, 1,  E_DEC,  0);
        add("ill9_x",   0, 9,  0,  1, 14, E_ILL,  0);
        add("ill9_next",0, 9,  0,  0, 0,  E_FW,   0);

        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_i);
            rst_i         = vecs[i].rst;
            instr_op_i    = vecs[i].op;
            instr_funct_i = vecs[i].fn;
            mem_ready_i   = vecs[i].rdy;
            #1;
            check($sformatf("%s/state", vecs[i].name), {28'd0, state_o}, {28'd0, vecs[i].st});
            check($sformatf("%s/ctl", vecs[i].name), {8'd0, act}, {8'd0, vecs[i].exp});
            check($sformatf("%s/count", vecs[i].name), instr_count_o, vecs[i].cnt);
        end

        // Reset-to-retire latency with the memory always ready.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            rst_i = 1'b1; mem_ready_i = 1'b1;
            instr_op_i = lat_op[k]; instr_funct_i = lat_fn[k];
            @(negedge clk_i);
            rst_i = 1'b0;
            cyc = 0; done = 1'b0;
            while (!done && cyc < 20) begin
                @(posedge clk_i);
                #1;
                cyc++;
                if (instr_count_o == 32'd1) done = 1'b1;
            end
            check($sformatf("latency_op%0d", lat_op[k]), cyc, lat_exp[k]);
        end

        // Long FETCH stall: request and address select held steady.
        @(negedge clk_i);
        rst_i = 1'b1; mem_ready_i = 1'b0; instr_op_i = 6'd8; instr_funct_i = 6'd0;
        @(negedge clk_i);
        rst_i = 1'b0;
`ifdef MC_CTRL_TIMEOUT_EN
        cyc = 0; done = 1'b0;
        while (!done && cyc < 40) begin
            #1;
            cyc++;
            if (trap_o) done = 1'b1;
            else @(negedge clk_i);
        end
        check("timeout_wait_cycles", cyc - 1, 16);
        check("timeout_state", {28'd0, state_o}, 32'd15);
        @(negedge clk_i);
        mem_ready_i = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk_i);
            #1;
            if (!trap_o || state_o != 4'd15 || mem_read_o) bad++;
        end
        check("trap_sticky", bad, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("trap_in_reset", {31'd0, trap_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("trap_cleared_state", {28'd0, state_o}, 32'd0);
`else
        bad = 0;
        repeat (30) begin
            #1;
            if (state_o != 4'd0 || !mem_read_o || iord_o || ir_write_o || trap_o) bad++;
            @(negedge clk_i);
        end
        check("fetch_stall_stable", bad, 0);
        mem_ready_i = 1'b1;
        @(negedge clk_i);
        #1;
        check("fetch_stall_release", {28'd0, state_o}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
